// File: rtl/utc_time_pkg.sv
// Shared types and constants for the UTC/GNSS time receiver.
// Optional holdover limit in utc_time_rx is enabled by UTC_TIME_HOLDOVER_LIMIT_EN.
package utc_time_pkg;

  localparam logic [7:0]  UTC_HDR0        = 8'hAA;
  localparam logic [7:0]  UTC_HDR1        = 8'h55;
  localparam int unsigned UTC_PAYLOAD_LEN = 6;
  localparam int unsigned SEC_PER_WEEK    = 604800;

  localparam int unsigned TOW_W     = 20;
  localparam int unsigned WEEK_W    = 16;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned PAYLOAD_W = 8 * UTC_PAYLOAD_LEN;

  typedef enum logic [1:0] {
    PS_HUNT_AA,
    PS_HUNT_55,
    PS_PAYLOAD,
    PS_CSUM
  } parse_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic [TOW_W-1:0]  tow;
    logic [WEEK_W-1:0] week;
  } utc_time_t;

  // Advance one second, rolling the week at the end of time-of-week.
  function automatic utc_time_t next_second(input utc_time_t t);
    utc_time_t n;
    n = t;
    if (t.tow == TOW_W'(SEC_PER_WEEK - 1)) begin
      n.tow  = '0;
      n.week = t.week + WEEK_W'(1);
    end else begin
      n.tow = t.tow + TOW_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver on an already-synchronised line; mid-bit sampling,
// false-start rejection and stop-bit error reporting.
module uart_rx_byte
  import utc_time_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 710
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       byte_valid_o,
  output logic       stop_err_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             stop_err_q, stop_err_d;
  logic             rxd_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      stop_err_q <= 1'b0;
      rxd_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      stop_err_q <= stop_err_d;
      rxd_prev_q <= rxd_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    stop_err_d = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (!rxd_i && rxd_prev_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // A line back high at mid start bit was a glitch, not a character.
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_i ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_i, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rxd_i) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            stop_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data_o       = data_q;
  assign byte_valid_o = valid_q;
  assign stop_err_o   = stop_err_q;

endmodule

// File: rtl/utc_time_rx.sv
// UTC time message receiver: parses framed TOW/WEEK bytes and applies them at PPS.
// Define UTC_TIME_HOLDOVER_LIMIT_EN to drop lock after MAX_HOLDOVER extrapolated seconds.
module utc_time_rx
  import utc_time_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 81840000,
  parameter int unsigned BAUD         = 115200
`ifdef UTC_TIME_HOLDOVER_LIMIT_EN
  ,
  parameter int unsigned MAX_HOLDOVER = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              UTC_UART_RXD,
  input  logic              PPS_IN,
  output logic              time_valid_o,
  output logic [TOW_W-1:0]  tow_o,
  output logic [WEEK_W-1:0] week_o,
  output logic              holdover_o,
  output logic              time_locked_o,
  output logic              frame_err_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned GAP_LIMIT    = 20 * CLKS_PER_BIT;
  localparam int unsigned GAP_W        = $clog2(GAP_LIMIT + 1);

  logic rxd_s1_q, rxd_s2_q;
  logic pps_s1_q, pps_s2_q, pps_prev_q, pps_edge_q;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_stop_err;

  parse_state_e         pstate_q, pstate_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [7:0]           csum_q, csum_d;
  logic [GAP_W-1:0]     gap_q, gap_d;

  logic      pending_q, pending_d;
  utc_time_t pending_time_q, pending_time_d;
  utc_time_t time_q, time_d;
  logic      time_valid_q, time_valid_d;
  logic      holdover_q, holdover_d;
  logic      locked_q, locked_d;
  logic      frame_err_q, frame_err_d;

`ifdef UTC_TIME_HOLDOVER_LIMIT_EN
  localparam int unsigned HC_W = $clog2(MAX_HOLDOVER + 1);
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rxd_i       (rxd_s2_q),
    .data_o      (rx_data),
    .byte_valid_o(rx_valid),
    .stop_err_o  (rx_stop_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1_q       <= 1'b1;
      rxd_s2_q       <= 1'b1;
      pps_s1_q       <= 1'b0;
      pps_s2_q       <= 1'b0;
      pps_prev_q     <= 1'b0;
      pps_edge_q     <= 1'b0;
      pstate_q       <= PS_HUNT_AA;
      idx_q          <= '0;
      payload_q      <= '0;
      csum_q         <= '0;
      gap_q          <= '0;
      pending_q      <= 1'b0;
      pending_time_q <= '0;
      time_q         <= '0;
      time_valid_q   <= 1'b0;
      holdover_q     <= 1'b0;
      locked_q       <= 1'b0;
      frame_err_q    <= 1'b0;
`ifdef UTC_TIME_HOLDOVER_LIMIT_EN
      hold_cnt_q     <= '0;
`endif
    end else begin
      rxd_s1_q       <= UTC_UART_RXD;
      rxd_s2_q       <= rxd_s1_q;
      pps_s1_q       <= PPS_IN;
      pps_s2_q       <= pps_s1_q;
      pps_prev_q     <= pps_s2_q;
      pps_edge_q     <= pps_s2_q & ~pps_prev_q;
      pstate_q       <= pstate_d;
      idx_q          <= idx_d;
      payload_q      <= payload_d;
      csum_q         <= csum_d;
      gap_q          <= gap_d;
      pending_q      <= pending_d;
      pending_time_q <= pending_time_d;
      time_q         <= time_d;
      time_valid_q   <= time_valid_d;
      holdover_q     <= holdover_d;
      locked_q       <= locked_d;
      frame_err_q    <= frame_err_d;
`ifdef UTC_TIME_HOLDOVER_LIMIT_EN
      hold_cnt_q     <= hold_cnt_d;
`endif
    end
  end

  always_comb begin
    pstate_d       = pstate_q;
    idx_d          = idx_q;
    payload_d      = payload_q;
    csum_d         = csum_q;
    gap_d          = gap_q;
    pending_d      = pending_q;
    pending_time_d = pending_time_q;
    time_d         = time_q;
    time_valid_d   = 1'b0;
    holdover_d     = holdover_q;
    locked_d       = locked_q;
    frame_err_d    = 1'b0;
`ifdef UTC_TIME_HOLDOVER_LIMIT_EN
    hold_cnt_d     = hold_cnt_q;
`endif

    // PPS sees pending as it stood before any frame completing this cycle.
    if (pps_edge_q) begin
      if (pending_q) begin
        time_d       = pending_time_q;
        pending_d    = 1'b0;
        holdover_d   = 1'b0;
        locked_d     = 1'b1;
        time_valid_d = 1'b1;
`ifdef UTC_TIME_HOLDOVER_LIMIT_EN
        hold_cnt_d   = '0;
`endif
      end else if (locked_q) begin
`ifdef UTC_TIME_HOLDOVER_LIMIT_EN
        if (hold_cnt_q == HC_W'(MAX_HOLDOVER)) begin
          locked_d   = 1'b0;
          holdover_d = 1'b0;
          hold_cnt_d = '0;
        end else begin
          time_d       = next_second(time_q);
          holdover_d   = 1'b1;
          time_valid_d = 1'b1;
          hold_cnt_d   = hold_cnt_q + HC_W'(1);
        end
`else
        time_d       = next_second(time_q);
        holdover_d   = 1'b1;
        time_valid_d = 1'b1;
`endif
      end
    end

    if (rx_stop_err) begin
      pstate_d    = PS_HUNT_AA;
      gap_d       = '0;
      frame_err_d = 1'b1;
    end else if (rx_valid) begin
      gap_d = '0;
      case (pstate_q)
        PS_HUNT_AA: begin
          if (rx_data == UTC_HDR0) pstate_d = PS_HUNT_55;
        end
        PS_HUNT_55: begin
          if (rx_data == UTC_HDR1) begin
            pstate_d = PS_PAYLOAD;
            idx_d    = '0;
            csum_d   = '0;
          end else if (rx_data != UTC_HDR0) begin
            pstate_d = PS_HUNT_AA;
          end
        end
        PS_PAYLOAD: begin
          payload_d = {payload_q[PAYLOAD_W-9:0], rx_data};
          csum_d    = csum_q ^ rx_data;
          if (idx_q == IDX_W'(UTC_PAYLOAD_LEN - 1)) begin
            pstate_d = PS_CSUM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        PS_CSUM: begin
          pstate_d = PS_HUNT_AA;
          if (rx_data == csum_q &&
              payload_q[PAYLOAD_W-1 -: 32] < 32'(SEC_PER_WEEK)) begin
            pending_d           = 1'b1;
            pending_time_d.tow  = payload_q[WEEK_W +: TOW_W];
            pending_time_d.week = payload_q[WEEK_W-1:0];
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: pstate_d = PS_HUNT_AA;
      endcase
    end else if (pstate_q == PS_HUNT_AA) begin
      gap_d = '0;
    end else if (gap_q == GAP_W'(GAP_LIMIT)) begin
      pstate_d    = PS_HUNT_AA;
      gap_d       = '0;
      frame_err_d = 1'b1;
    end else begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  assign time_valid_o  = time_valid_q;
  assign tow_o         = time_q.tow;
  assign week_o        = time_q.week;
  assign holdover_o    = holdover_q;
  assign time_locked_o = locked_q;
  assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_utc_time_rx.sv
// Directed bench for utc_time_rx at 16 clocks per UART bit.
// Holdover-limit steps run only when UTC_TIME_HOLDOVER_LIMIT_EN is defined.
module tb_utc_time_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        pps = 1'b0;
  logic        time_valid_o;
  logic [19:0] tow_o;
  logic [15:0] week_o;
  logic        holdover_o;
  logic        time_locked_o;
  logic        frame_err_o;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;
  int e0;

  logic        cap_tv;
  logic [19:0] cap_tow;
  logic [15:0] cap_week;
  logic        cap_hold;

  always #5 clk = ~clk;

  utc_time_rx #(
    .CLK_FREQ_HZ(1600000),
    .BAUD       (100000)
`ifdef UTC_TIME_HOLDOVER_LIMIT_EN
    ,
    .MAX_HOLDOVER(2)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .UTC_UART_RXD (rxd),
    .PPS_IN       (pps),
    .time_valid_o (time_valid_o),
    .tow_o        (tow_o),
    .week_o       (week_o),
    .holdover_o   (holdover_o),
    .time_locked_o(time_locked_o),
    .frame_err_o  (frame_err_o)
  );

  always @(negedge clk) if (frame_err_o === 1'b1) err_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One 8N1 character; optionally raise PPS at negedge pps_at of the character.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int pps_at);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(negedge clk);
    rxd = bits[0];
    for (int k = 1; k <= 10 * CPB; k++) begin
      @(negedge clk);
      if (k < 10 * CPB) rxd = bits[k / CPB];
      else rxd = 1'b1;
      if (pps_at > 0) begin
        if (k == pps_at) pps = 1'b1;
        if (k == pps_at + 6) pps = 1'b0;
        if (k == pps_at + 4) begin
          cap_tv   = time_valid_o;
          cap_tow  = tow_o;
          cap_week = week_o;
          cap_hold = holdover_o;
        end
      end
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] tow, input logic [15:0] week,
                            input logic [7:0] flip, input int pps_at);
    logic [7:0] fb [9];
    fb[0] = 8'hAA;
    fb[1] = 8'h55;
    fb[2] = tow[31:24];
    fb[3] = tow[23:16];
    fb[4] = tow[15:8];
    fb[5] = tow[7:0];
    fb[6] = week[15:8];
    fb[7] = week[7:0];
    fb[8] = fb[2] ^ fb[3] ^ fb[4] ^ fb[5] ^ fb[6] ^ fb[7] ^ flip;
    for (int i = 0; i < 8; i++) send_byte(fb[i], 1'b1, -1);
    send_byte(fb[8], 1'b1, pps_at);
    idle_bits(2);
  endtask

  // PPS pin rises at a negedge; strobe expected after the 4th following posedge.
  task automatic pps_pulse(input string tag, input logic exp_tv, input logic [31:0] exp_tow,
                           input logic [31:0] exp_week, input logic exp_hold, input logic exp_lock);
    @(negedge clk);
    pps = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_early"}, 32'(time_valid_o), 32'(1'b0));
    @(negedge clk);
    check({tag, "_strobe"}, 32'(time_valid_o), 32'(exp_tv));
    if (exp_tv) begin
      check({tag, "_tow"}, 32'(tow_o), exp_tow);
      check({tag, "_week"}, 32'(week_o), exp_week);
    end
    check({tag, "_hold"}, 32'(holdover_o), 32'(exp_hold));
    check({tag, "_lock"}, 32'(time_locked_o), 32'(exp_lock));
    @(negedge clk);
    check({tag, "_onecyc"}, 32'(time_valid_o), 32'(1'b0));
    pps = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #3 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_tv", 32'(time_valid_o), 0);
    check("rst_tow", 32'(tow_o), 0);
    check("rst_week", 32'(week_o), 0);
    check("rst_hold", 32'(holdover_o), 0);
    check("rst_lock", 32'(time_locked_o), 0);
    check("rst_ferr", 32'(frame_err_o), 0);
    rst = 1'b1;
    idle_bits(2);

    // Bad checksum (0x80 instead of 0x85), then not locked.
    e0 = err_seen;
    send_frame(300, 2208, 8'h05, -1);
    check("badcsum_err", 32'(err_seen - e0), 1);
    pps_pulse("nolock", 1'b0, 0, 0, 1'b0, 1'b0);

    // TOW out of range.
    e0 = err_seen;
    send_frame(604800, 1, 8'h00, -1);
    check("tow_range_err", 32'(err_seen - e0), 1);

    e0 = err_seen;
    send_frame(300, 2208, 8'h00, -1);
    check("good1_err", 32'(err_seen - e0), 0);
    pps_pulse("apply300", 1'b1, 300, 2208, 1'b0, 1'b1);
    pps_pulse("extrap301", 1'b1, 301, 2208, 1'b1, 1'b1);
    pps_pulse("extrap302", 1'b1, 302, 2208, 1'b1, 1'b1);

    send_frame(604799, 2208, 8'h00, -1);
    pps_pulse("apply_eow", 1'b1, 604799, 2208, 1'b0, 1'b1);
    pps_pulse("wrap_week", 1'b1, 0, 2209, 1'b1, 1'b1);

    // Bad frame while locked keeps extrapolating.
    e0 = err_seen;
    send_frame(77, 9, 8'h01, -1);
    check("badlocked_err", 32'(err_seen - e0), 1);
    pps_pulse("extrap_after_bad", 1'b1, 1, 2209, 1'b1, 1'b1);

    // Stop bit forced low on the 4th byte.
    e0 = err_seen;
    send_byte(8'hAA, 1'b1, -1);
    send_byte(8'h55, 1'b1, -1);
    send_byte(8'h00, 1'b1, -1);
    send_byte(8'h00, 1'b0, -1);
    idle_bits(2);
    check("stopbit_err", 32'(err_seen - e0), 1);
    e0 = err_seen;
    send_frame(1000, 5, 8'h00, -1);
    check("stopbit_recover_err", 32'(err_seen - e0), 0);
    pps_pulse("after_stopbit", 1'b1, 1000, 5, 1'b0, 1'b1);

    // 30-bit-time gap after the third byte.
    e0 = err_seen;
    send_byte(8'hAA, 1'b1, -1);
    send_byte(8'h55, 1'b1, -1);
    send_byte(8'h00, 1'b1, -1);
    idle_bits(30);
    check("timeout_err", 32'(err_seen - e0), 1);
    send_frame(2000, 6, 8'h00, -1);
    pps_pulse("after_timeout", 1'b1, 2000, 6, 1'b0, 1'b1);

    // PPS edge in the same cycle as the checksum byte completes.
    send_frame(5000, 7, 8'h00, 152);
    check("simul_tv", 32'(cap_tv), 1);
    check("simul_tow", 32'(cap_tow), 2001);
    check("simul_week", 32'(cap_week), 6);
    check("simul_hold", 32'(cap_hold), 1);
    pps_pulse("simul_next", 1'b1, 5000, 7, 1'b0, 1'b1);

    // Asynchronous reset mid-frame.
    send_byte(8'hAA, 1'b1, -1);
    send_byte(8'h55, 1'b1, -1);
    send_byte(8'h00, 1'b1, -1);
    send_byte(8'h00, 1'b1, -1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_tow", 32'(tow_o), 0);
    check("mid_rst_week", 32'(week_o), 0);
    check("mid_rst_lock", 32'(time_locked_o), 0);
    check("mid_rst_hold", 32'(holdover_o), 0);
    check("mid_rst_tv", 32'(time_valid_o), 0);
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'h03, 1'b1, -1);
    send_byte(8'hE8, 1'b1, -1);
    send_byte(8'h00, 1'b1, -1);
    send_byte(8'h05, 1'b1, -1);
    send_byte(8'hEE, 1'b1, -1);
    idle_bits(2);
    pps_pulse("after_mid_rst", 1'b0, 0, 0, 1'b0, 1'b0);

`ifdef UTC_TIME_HOLDOVER_LIMIT_EN
    send_frame(100, 1, 8'h00, -1);
    pps_pulse("hl_apply", 1'b1, 100, 1, 1'b0, 1'b1);
    pps_pulse("hl_ext1", 1'b1, 101, 1, 1'b1, 1'b1);
    pps_pulse("hl_ext2", 1'b1, 102, 1, 1'b1, 1'b1);
    pps_pulse("hl_drop", 1'b0, 0, 0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
